irq_conditioner: RTL



---
 rtl/irq_cond_pkg.sv | 18 +
 rtl/irq_line_cond.sv | 113 +++++++++++
 rtl/irq_conditioner.sv | 109 ++++++++++
 3 files changed

// File: rtl/irq_cond_pkg.sv
// Shared definitions for the interrupt conditioner.
// Contents:
//   REG_MODE / REG_ENABLE / REG_PENDING / REG_RAW - word addresses of the
//                                                    register window
//   NUM_IRQ_DEFAULT                               - interrupt width that
//                                                    matches the CP0 input
//   DATA_W                                        - data bus width
package irq_cond_pkg;

    localparam int unsigned NUM_IRQ_DEFAULT = 6;
    localparam int unsigned DATA_W          = 32;

    localparam logic [1:0] REG_MODE    = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_PENDING = 2'd2;
    localparam logic [1:0] REG_RAW     = 2'd3;

endpackage : irq_cond_pkg

// File: rtl/irq_line_cond.sv
// Conditioning for a single interrupt line: input synchroniser, optional
// debounce filter, previous-sample edge detector and the pending bit.
// Optional feature: define IRQ_DEBOUNCE_EN to insert a stability counter
// between the synchroniser and the edge/level logic.
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active-high
//   irq_i      - asynchronous raw request
//   mode_i     - 1 = edge mode, 0 = level mode (current register value)
//   clear_i    - write-1-to-clear strobe for this line's pending bit
//   mode_chg_i - this line's mode is being changed this cycle
//   s_o        - synchronised request (last synchroniser stage)
//   pending_o  - pending state
module irq_line_cond #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_i,
    input  logic mode_i,
    input  logic clear_i,
    input  logic mode_chg_i,
    output logic s_o,
    output logic pending_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   f;
    logic                   prev_q;
    logic                   pending_q, pending_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_i};
        end
    end

    assign s_o = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       f_q, f_d;
    logic [7:0] cnt_q, cnt_d;

    // The counter measures how long s has disagreed with the filtered
    // level; any agreement restarts the count.
    // NOTE: every signal written in this block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        f_d   = f_q;
        cnt_d = '0;
        if (s_o != f_q) begin
            if (cnt_q == DB_LAST) begin
                f_d = s_o;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            cnt_q <= cnt_d;
        end
    end

    assign f = f_q;
`else
    assign f = s_o;
`endif

    // A mode change wipes the bit so stale state from the old rule never
    // leaks into the new one. In edge mode a fresh edge beats a
    // simultaneous clear so the new event is not lost.
    always_comb begin
        pending_d = pending_q;
        if (mode_chg_i) begin
            pending_d = 1'b0;
        end else if (mode_i) begin
            if (f & ~prev_q) begin
                pending_d = 1'b1;
            end else if (clear_i) begin
                pending_d = 1'b0;
            end
        end else begin
            pending_d = f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= f;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule : irq_line_cond

// File: rtl/irq_conditioner.sv
// Interrupt conditioner in front of the CP0 interrupt input. Each line is
// synchronised, processed in edge or level mode, latched as pending,
// masked by ENABLE and registered onto irq_out.
// Optional feature: define IRQ_DEBOUNCE_EN to debounce each line for
// DEBOUNCE_CYCLES clocks after the synchroniser.
// Ports:
//   clk     - system clock
//   rst     - synchronous reset, active-high
//   irq_in  - asynchronous raw interrupt requests
//   we      - register write strobe
//   addr    - register select: 0 MODE, 1 ENABLE, 2 PENDING (W1C), 3 RAW
//   wd      - write data, low NUM_IRQ bits used
//   rd      - combinational read data for addr, upper bits zero
//   irq_out - registered interrupt vector to CP0
module irq_conditioner
    import irq_cond_pkg::*;
#(
    parameter int unsigned NUM_IRQ         = NUM_IRQ_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               we,
    input  logic [1:0]         addr,
    input  logic [DATA_W-1:0]  wd,
    output logic [DATA_W-1:0]  rd,
    output logic [NUM_IRQ-1:0] irq_out
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("irq_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES 1..255");
    end

    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] irq_out_q;
    logic [NUM_IRQ-1:0] mode_chg;
    logic [NUM_IRQ-1:0] clear;
    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] wd_lo;
    logic               unused_wd_hi;

    assign wd_lo        = wd[NUM_IRQ-1:0];
    assign unused_wd_hi = ^wd[DATA_W-1:NUM_IRQ];

    // Write decode. A MODE write flags only the lines whose mode actually
    // flips; RAW is read-only so writes to it fall through to no effect.
    always_comb begin
        mode_d   = mode_q;
        enable_d = enable_q;
        mode_chg = '0;
        clear    = '0;
        if (we) begin
            case (addr)
                REG_MODE: begin
                    mode_d   = wd_lo;
                    mode_chg = wd_lo ^ mode_q;
                end
                REG_ENABLE:  enable_d = wd_lo;
                REG_PENDING: clear    = wd_lo;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= '0;
            enable_q  <= '0;
            irq_out_q <= '0;
        end else begin
            mode_q    <= mode_d;
            enable_q  <= enable_d;
            irq_out_q <= pending & enable_q;
        end
    end

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_line_cond #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line (
            .clk        (clk),
            .rst        (rst),
            .irq_i      (irq_in[i]),
            .mode_i     (mode_q[i]),
            .clear_i    (clear[i]),
            .mode_chg_i (mode_chg[i]),
            .s_o        (s[i]),
            .pending_o  (pending[i])
        );
    end

    always_comb begin
        rd = '0;
        case (addr)
            REG_MODE:    rd[NUM_IRQ-1:0] = mode_q;
            REG_ENABLE:  rd[NUM_IRQ-1:0] = enable_q;
            REG_PENDING: rd[NUM_IRQ-1:0] = pending;
            default:     rd[NUM_IRQ-1:0] = s;
        endcase
    end

    assign irq_out = irq_out_q;

endmodule : irq_conditioner
